bla_sub_pipe: RTL and testbench
===============================

Name: bla_sub_pipe

Overview:
- Parametrised, pipelined borrow-look-ahead subtractor: computes a - b - bin over WIDTH bits in STAGES register stages, one GROUP-bit slice per stage.
- Registered borrow passed between stages; per-group borrow generate/propagate look-ahead inside each stage.
- Produces result plus borrow/zero/negative/overflow flags.
- Sits in the ALU datapath behind the issue logic; valid/ready handshake on both sides, global stall, synchronous flush.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of GROUP.
- GROUP, 8, bits resolved per pipeline stage.
- STAGES, WIDTH/GROUP, derived localparam; pipeline depth and latency.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all in-flight operations.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in to bit 0.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  out  1  borrow out of MSB; 1 when unsigned a < b + bin.
- zero  out  1  diff == 0.
- neg  out  1  diff[WIDTH-1].
- ovf  out  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).

Behaviour:
- Reset (rst_n low, async): all stage valid bits 0, out_valid 0, diff 0, bout 0, zero 0, neg 0, ovf 0. Datapath registers cleared. in_ready = 0 while rst_n is low.
- Per-bit terms: g = ~a & b; p = a XNOR b.
- Group borrow chain: borrow(i+1) = g(i) | (p(i) & borrow(i)).
- diff(i) = p(i) XNOR borrow(i).
- Look-ahead: borrows within a group are computed from g/p/carry-in in parallel, not bit-ripple.
- Stage registers R0..R(STAGES-1), each holding: valid, full a, full b, diff bits resolved so far, borrow into the next group, running zero (AND of group zeros).
- Group 0 logic sits between the inputs and R0. Group k logic sits between R(k-1) and R(k).
- Flags are computed in the final group logic and registered in R(STAGES-1).
- Outputs drive directly from R(STAGES-1).
- Global advance = ~out_valid | out_ready.
  - All stages shift only when advance is 1.
  - in_ready = advance & ~flush & rst_n.
- Transfer: an input is accepted on a rising edge with in_valid & in_ready. An output is consumed on a rising edge with out_valid & out_ready.
- Latency: an operand accepted at edge E gives out_valid=1 after edge E+STAGES-1, i.e. STAGES edges including the accept edge.
  - Throughput: 1 result/cycle when out_ready is held high.
  - STAGES=1 degenerates to a single registered stage.
- Stall: when advance is 0, every register holds. diff and flags stay stable while out_valid=1 & out_ready=0. No operation is dropped or duplicated.
- Bubbles: an invalid input cycle propagates as valid=0. Bubbles are not collapsed (global stall).
- Flush: at the next edge all valid bits clear and out_valid drops to 0.
  - flush overrides in_valid; no accept that cycle.
  - Data registers may hold stale values; checked only qualified by valid.
- Wrap-around: results are modulo 2^WIDTH. bout gives the unsigned borrow; ovf gives the signed overflow.
  - bin=1 with a=b yields all-ones, bout=1.
- Reset mid-operation clears all in-flight work immediately (async). The first accept is possible on the first edge after rst_n rises.

Decomposition:
- Shared package alu_pkg holds: flag index constants (FLAG_BOUT=0, FLAG_ZERO=1, FLAG_NEG=2, FLAG_OVF=3) and the default GROUP width.
- One natural sub-module: bla_group, a combinational GROUP-bit borrow-look-ahead slice.
  - Inputs: a, b, borrow-in.
  - Outputs: diff, borrow-out, group-zero.
- STAGES instances are generated, one per pipeline stage.

Test Plan (WIDTH=32, GROUP=8, latency 4):
- a=5, b=3, bin=0 accepted at edge 0 -> out_valid after edge 3: diff=0x00000002, bout=0, zero=0, neg=0, ovf=0.
- a=0, b=1, bin=0 -> diff=0xFFFFFFFF, bout=1, neg=1, ovf=0. Then a=0, b=0, bin=1 -> diff=0xFFFFFFFF, bout=1 (borrow ripples through all 4 stages).
- a=0x80000000, b=1 -> diff=0x7FFFFFFF, ovf=1, neg=0, bout=0. a=0x12345678, b=0x12345678 -> diff=0, zero=1.
- Back-to-back 6 random ops with out_ready low for 3 cycles after first out_valid -> in_ready low during stall, outputs stable, all 6 results in order, matching a reference model.
- 3 ops in flight, flush=1 together with in_valid=1 -> next cycle out_valid=0, no result emitted, that input not accepted. The next op returns after 4 edges.
- Pull rst_n low with 2 ops in flight -> immediately out_valid=0 and all outputs 0. After release, a new op completes with correct result and latency 4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions and the default look-ahead group width.
package alu_pkg;

    localparam int unsigned FLAG_BOUT     = 0;
    localparam int unsigned FLAG_ZERO     = 1;
    localparam int unsigned FLAG_NEG      = 2;
    localparam int unsigned FLAG_OVF      = 3;
    localparam int unsigned NUM_FLAGS     = 4;
    localparam int unsigned GROUP_DEFAULT = 8;

endpackage

// File: rtl/bla_group.sv
// Combinational GROUP-bit borrow-look-ahead subtractor slice.
module bla_group #(
    parameter int unsigned GROUP = 8
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             bin,
    output logic [GROUP-1:0] diff,
    output logic             bout,
    output logic             zero
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   bw;
    logic             pp;

    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Each borrow is a flat sum of products of g, p and bin rather than a ripple.
    always_comb begin
        bw = '0;
        pp = 1'b1;
        for (int i = 0; i <= int'(GROUP); i++) begin
            pp = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                bw[i] = bw[i] | (g[j] & pp);
                pp    = pp & p[j];
            end
            bw[i] = bw[i] | (pp & bin);
        end
    end

    assign diff = ~(p ^ bw[GROUP-1:0]);
    assign bout = bw[GROUP];
    assign zero = ~|diff;

endmodule

// File: rtl/bla_sub_pipe.sv
// Pipelined borrow-look-ahead subtractor: one GROUP-bit slice per stage, global stall,
// synchronous flush, valid/ready on both sides.
module bla_sub_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = GROUP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / GROUP;

    logic                 advance;
    logic [NUM_FLAGS-1:0] flags_q;

    // Operands of each group's logic: index k is what feeds stage register Rk.
    logic             in_v  [STAGES];
    logic [WIDTH-1:0] in_a  [STAGES];
    logic [WIDTH-1:0] in_b  [STAGES];
    logic [WIDTH-1:0] in_d  [STAGES];
    logic             in_bw [STAGES];
    logic             in_z  [STAGES];

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance & ~flush & rst_n;

    assign in_v[0]  = in_valid;
    assign in_a[0]  = a;
    assign in_b[0]  = b;
    assign in_d[0]  = '0;
    assign in_bw[0] = bin;
    assign in_z[0]  = 1'b1;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [GROUP-1:0] gd;
        logic             gb;
        logic             gz;
        logic [WIDTH-1:0] dn;

        bla_group #(
            .GROUP(GROUP)
        ) u_group (
            .a    (in_a[k][k*GROUP +: GROUP]),
            .b    (in_b[k][k*GROUP +: GROUP]),
            .bin  (in_bw[k]),
            .diff (gd),
            .bout (gb),
            .zero (gz)
        );

        // Upper diff bits are still zero here, so OR merges this group's slice in.
        assign dn = in_d[k] | (WIDTH'(gd) << (k * GROUP));

        if (k < STAGES - 1) begin : g_mid
            logic             v_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] d_q;
            logic             bw_q;
            logic             z_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q  <= 1'b0;
                    a_q  <= '0;
                    b_q  <= '0;
                    d_q  <= '0;
                    bw_q <= 1'b0;
                    z_q  <= 1'b0;
                end else if (flush) begin
                    v_q <= 1'b0;
                end else if (advance) begin
                    v_q  <= in_v[k];
                    a_q  <= in_a[k];
                    b_q  <= in_b[k];
                    d_q  <= dn;
                    bw_q <= gb;
                    z_q  <= in_z[k] & gz;
                end
            end

            assign in_v[k+1]  = v_q;
            assign in_a[k+1]  = a_q;
            assign in_b[k+1]  = b_q;
            assign in_d[k+1]  = d_q;
            assign in_bw[k+1] = bw_q;
            assign in_z[k+1]  = z_q;
        end else begin : g_last
            logic [NUM_FLAGS-1:0] fl;

            always_comb begin
                fl            = '0;
                fl[FLAG_BOUT] = gb;
                fl[FLAG_ZERO] = in_z[k] & gz;
                fl[FLAG_NEG]  = dn[WIDTH-1];
                fl[FLAG_OVF]  = (in_a[k][WIDTH-1] != in_b[k][WIDTH-1]) &&
                                (dn[WIDTH-1] != in_a[k][WIDTH-1]);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    diff      <= '0;
                    flags_q   <= '0;
                end else if (flush) begin
                    out_valid <= 1'b0;
                end else if (advance) begin
                    out_valid <= in_v[k];
                    diff      <= dn;
                    flags_q   <= fl;
                end
            end
        end
    end

    assign bout = flags_q[FLAG_BOUT];
    assign zero = flags_q[FLAG_ZERO];
    assign neg  = flags_q[FLAG_NEG];
    assign ovf  = flags_q[FLAG_OVF];

endmodule

// File: tb/tb_bla_sub_pipe.sv
// Self-checking bench for bla_sub_pipe: directed vectors, random scoreboard, stall/flush/reset.
module tb_bla_sub_pipe;
    import alu_pkg::*;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned GROUP  = 8;
    localparam int unsigned STAGES = WIDTH / GROUP;
    localparam int unsigned NVEC   = 9;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             zero;
        logic             neg;
        logic             ovf;
    } res_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             bin;
        res_t             exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             neg;
    logic             ovf;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    int          n_acc  = 0;
    int          n_out  = 0;
    res_t        exp_q[$];
    vec_t        vecs[NVEC];

    bla_sub_pipe #(
        .WIDTH(WIDTH),
        .GROUP(GROUP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic c);
        res_t   r;
        longint ud;
        longint sd;
        longint lim;
        ud     = longint'(x) - longint'(y) - longint'(c);
        sd     = longint'($signed(x)) - longint'($signed(y)) - longint'(c);
        lim    = longint'(1) <<< (WIDTH - 1);
        r.diff = ud[WIDTH-1:0];
        r.bout = (ud < 0);
        r.zero = (r.diff == '0);
        r.neg  = ($signed(r.diff) < 0);
        r.ovf  = (sd >= lim) || (sd < -lim);
        return r;
    endfunction

    function automatic vec_t mkv(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c, input logic [WIDTH-1:0] d, input logic bo,
                                 input logic z, input logic n, input logic o);
        vec_t v;
        v.a        = x;
        v.b        = y;
        v.bin      = c;
        v.exp.diff = d;
        v.exp.bout = bo;
        v.exp.zero = z;
        v.exp.neg  = n;
        v.exp.ovf  = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic, output int unsigned acc);
        bit ok;
        ok       = 1'b0;
        a        = ia;
        b        = ib;
        bin      = ic;
        in_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("accept");
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int unsigned acc, output int lat, output res_t got);
        bit ok;
        ok  = 1'b0;
        lat = -1;
        got = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid) begin
                ok       = 1'b1;
                lat      = int'(cyc - acc) + 1;
                got.diff = diff;
                got.bout = bout;
                got.zero = zero;
                got.neg  = neg;
                got.ovf  = ovf;
                break;
            end
        end
        if (!ok) timeout("result");
    endtask

    task automatic run_one(input string name, input logic [WIDTH-1:0] ia,
                           input logic [WIDTH-1:0] ib, input logic ic, input res_t exp);
        int unsigned acc;
        int          lat;
        res_t        got;
        out_ready = 1'b1;
        issue(ia, ib, ic, acc);
        wait_out(acc, lat, got);
        chk({name, "_diff"}, 64'(got.diff), 64'(exp.diff));
        chk({name, "_bout"}, 64'(got.bout), 64'(exp.bout));
        chk({name, "_zero"}, 64'(got.zero), 64'(exp.zero));
        chk({name, "_neg"},  64'(got.neg),  64'(exp.neg));
        chk({name, "_ovf"},  64'(got.ovf),  64'(exp.ovf));
        chk({name, "_lat"},  64'(lat),      64'(STAGES));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: decides at each falling edge what the coming rising edge transfers.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst_n || flush) begin
                if (rst_n) chk("flush_in_ready", 64'(in_ready), 64'(0));
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: output 0x%0h with nothing in flight", diff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_diff", 64'(diff), 64'(e.diff));
                        chk("sb_flags", 64'({bout, zero, neg, ovf}),
                            64'({e.bout, e.zero, e.neg, e.ovf}));
                    end
                    n_out++;
                end
                if (out_valid && !out_ready) chk("stall_in_ready", 64'(in_ready), 64'(0));
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_sub(a, b, bin));
                    n_acc++;
                end
            end
        end
    end

    initial begin
        int unsigned      acc;
        int unsigned      acc2;
        int               base_acc;
        int               base_out;
        bit               seen;
        logic [WIDTH-1:0] held;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        vecs[0] = mkv(32'd5,         32'd3,         1'b0, 32'h0000_0002, 0, 0, 0, 0);
        vecs[1] = mkv(32'd0,         32'd1,         1'b0, 32'hFFFF_FFFF, 1, 0, 1, 0);
        vecs[2] = mkv(32'd0,         32'd0,         1'b1, 32'hFFFF_FFFF, 1, 0, 1, 0);
        vecs[3] = mkv(32'h8000_0000, 32'd1,         1'b0, 32'h7FFF_FFFF, 0, 0, 0, 1);
        vecs[4] = mkv(32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 0, 1, 0, 0);
        vecs[5] = mkv(32'd5,         32'd5,         1'b1, 32'hFFFF_FFFF, 1, 0, 1, 0);
        vecs[6] = mkv(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1, 0, 1, 1);
        vecs[7] = mkv(32'h0000_0100, 32'd1,         1'b0, 32'h0000_00FF, 0, 0, 0, 0);
        vecs[8] = mkv(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1, 0, 1, 0);

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(0));
        chk("rst_outputs",   64'({diff, bout, zero, neg, ovf}), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        for (int i = 0; i < int'(NVEC); i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp);
        end

        // Six back-to-back ops; consumer stalls three cycles on the first result.
        base_out = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    ra = $urandom;
                    rb = (i == 3) ? ra : $urandom;
                    issue(ra, rb, 1'($urandom_range(0, 1)), acc);
                end
            end
            begin
                seen = 1'b0;
                for (int n = 0; n < 40; n++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) timeout("stall_first");
                out_ready = 1'b0;
                held      = diff;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_valid",    64'(out_valid), 64'(1));
                    chk("stall_hold",     64'(diff),      64'(held));
                    chk("stall_in_ready", 64'(in_ready),  64'(0));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n_out - base_out == 6 && !out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout("stall_drain");
        chk("stall_count", 64'(n_out - base_out), 64'(6));
        @(posedge clk);
        #1;

        // Random traffic with bubbles and random back-pressure.
        base_acc = n_acc;
        base_out = n_out;
        for (int i = 0; i < 200; i++) begin
            ra        = $urandom;
            in_valid  = ($urandom_range(0, 9) < 7);
            a         = ra;
            b         = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            bin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 6);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        seen      = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout("rand_drain");
        chk("rand_count", 64'(n_out - base_out), 64'(n_acc - base_acc));
        @(posedge clk);
        #1;

        // Flush with three ops in flight; the flush-cycle input must not be accepted.
        issue(32'd100, 32'd1, 1'b0, acc);
        issue(32'd200, 32'd2, 1'b0, acc);
        issue(32'd300, 32'd3, 1'b0, acc);
        flush    = 1'b1;
        in_valid = 1'b1;
        a        = 32'd77;
        b        = 32'd7;
        @(negedge clk);
        chk("flush_no_accept", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("flush_empty", 64'(out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        run_one("post_flush", 32'd50, 32'd8, 1'b1, ref_sub(32'd50, 32'd8, 1'b1));

        // Async reset with a stalled result and two more ops behind it.
        out_ready = 1'b0;
        issue(32'd10,        32'd3, 1'b0, acc);
        issue(32'hDEAD_BEEF, 32'd1, 1'b0, acc2);
        issue(32'h0F0F_0F0F, 32'd2, 1'b1, acc2);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        chk("pre_rst_diff",  64'(diff),      64'(7));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    64'(out_valid), 64'(0));
        chk("mid_rst_outputs",  64'({diff, bout, zero, neg, ovf}), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready),  64'(0));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_one("post_rst", 32'd0, 32'd9, 1'b0, ref_sub(32'd0, 32'd9, 1'b0));

        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
